threshold_alarm_monitor: RTL and testbench
==========================================

// Module: threshold_alarm_monitor
// PURPOSE
//  Receiving end of the threshold-update toggle interface driven by the warning-threshold
//  setter. Detects each trig_newd toggle, captures I_Temp/I_RH into shadow threshold
//  registers, compares every new sensor sample against them with confirm-count and
//  hysteresis, and drives per-channel alarm flags plus a pulsed buzzer output.
// PARAMETERS
//  TEMP_RST     26         threshold_temp reset value; matches setter reset
//  HUM_RST      60         threshold_hum reset value; matches setter reset
//  HYST         2          hysteresis units; clear needs value + HYST < threshold
//  CONFIRM_N    3          consecutive over-threshold samples to raise alarm (1..15)
//  BEEP_ON_CYC  25000000   clk cycles buzzer high per beep
//  BEEP_OFF_CYC 25000000   clk cycles buzzer low between beeps
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  trig_newd  in   1  toggle from setter; every edge = new threshold pair valid
//  I_Temp     in   8  temperature threshold from setter
//  I_RH       in   8  humidity threshold from setter
//  temp       in   8  sensor temperature sample, integer units
//  rh         in   8  sensor humidity sample, integer units
//  data_valid in   1  1-cycle pulse: temp/rh hold a new sample
//  mute       in   1  1-cycle pulse: silence buzzer for current alarm episode
//  thr_upd    out  1  1-cycle pulse: shadow thresholds just updated
//  alarm_temp out  1  temperature alarm, level
//  alarm_hum  out  1  humidity alarm, level
//  alarm_any  out  1  alarm_temp | alarm_hum (registered)
//  buzzer     out  1  beep pattern drive
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. Reset: trig_q=0, thr_temp=TEMP_RST,
//    thr_hum=HUM_RST, counters 0, all outputs 0, buzzer FSM OFF, muted=0.
//  - Toggle detect: new_thr = trig_newd ^ trig_q; trig_q <= trig_newd every cycle.
//    On new_thr, thr_temp<=I_Temp, thr_hum<=I_RH; thr_upd high the following cycle only.
//    Both toggle directions count; a toggle every cycle captures every pair.
//  - Same-cycle new_thr and data_valid: sample compared against OLD thresholds.
//  - Per channel on data_valid (9-bit unsigned math, no wrap):
//    over = value >= thr; under = value + HYST < thr.
//    over: cnt <= sat(cnt+1, CONFIRM_N); alarm set cycle after cnt reaches CONFIRM_N.
//    !over: cnt <= 0. under & alarm: alarm clears next cycle. Between: alarm holds.
//    thr < HYST: under never true; alarm clears only on reset.
//  - Threshold update zeroes both cnt; alarms hold until next sample's clear test.
//  - alarm_any registered OR, one cycle after alarm flags.
//  - Buzzer FSM: OFF -> ON when alarm_any & !muted (phase timer starts 0).
//    ON: buzzer=1, BEEP_ON_CYC cycles -> GAP. GAP: buzzer=0, BEEP_OFF_CYC cycles -> ON.
//    Any state: !alarm_any or muted -> OFF same cycle, timer cleared.
//  - mute pulse while alarm_any: muted<=1; muted clears when alarm_any falls, so the
//    next episode beeps again. mute while !alarm_any ignored.
//  - Reset mid-beep or mid-confirm: all state to reset values next edge.
// STRUCTURE
//  - Shared package: default thresholds (26/60), sample width 8, beep-timer width.
//  - Sub-module thr_channel_cmp (cnt, over/under, alarm flag) instantiated for temp
//    and for rh; toggle capture and buzzer FSM stay in the top.
// TESTING
//  1 Reset: thr 26/60, all outputs 0; temp=25 x3 valid -> alarm_temp stays 0.
//  2 temp=27 three data_valid pulses -> alarm_temp=1 after 3rd; temp=25 -> holds;
//    temp=23 -> clears next cycle (HYST=2, 23+2<26).
//  3 I_Temp=30, toggle trig_newd -> thr_upd pulse 1 cycle later, thr_temp=30;
//    temp=28 x3 -> no alarm. Same-cycle toggle + sample uses old threshold.
//  4 rh=70 x3 -> alarm_hum, alarm_any; buzzer (BEEP_*=4) 4 high/4 low repeat;
//    mute -> buzzer 0 next cycle; rh=50 clears; rh=70 x3 -> beeps again.
//  5 Back-to-back toggles on consecutive cycles with different I_RH -> last captured,
//    two thr_upd pulses; rst mid-beep -> buzzer 0, thresholds 26/60.

Source files
------------

// File: rtl/threshold_alarm_monitor_pkg.sv
// Shared widths, reset thresholds, buzzer state encoding and a saturating counter helper
// for the threshold alarm monitor.
package threshold_alarm_monitor_pkg;

  localparam int SAMPLE_W     = 8;
  localparam int SUM_W        = SAMPLE_W + 1;
  localparam int TEMP_RST_DEF = 26;
  localparam int HUM_RST_DEF  = 60;
  localparam int BEEP_TMR_W   = 25;
  localparam int CNT_W        = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  typedef enum logic [1:0] {
    BZ_OFF = 2'd0,
    BZ_ON  = 2'd1,
    BZ_GAP = 2'd2
  } buzz_state_t;

  function automatic cnt_t sat_inc(input cnt_t v, input cnt_t lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/threshold_alarm_monitor_cmp.sv
// One sensor channel: confirm counter, over/under-threshold test with hysteresis and
// the level alarm flag. The flag rises one cycle after the counter reaches the limit.
module thr_channel_cmp
  import threshold_alarm_monitor_pkg::*;
#(
  parameter int HYST      = 2,
  parameter int CONFIRM_N = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    sample_vld,
  input  sample_t value,
  input  sample_t thr,
  input  logic    clr_cnt,
  output logic    alarm
);

  localparam cnt_t             CONF   = CNT_W'(CONFIRM_N);
  localparam logic [SUM_W-1:0] HYST_W = SUM_W'(HYST);

  cnt_t cnt_d, cnt_q;
  logic alarm_d, alarm_q;
  logic over, under;

  always_comb begin
    over    = {1'b0, value} >= {1'b0, thr};
    under   = ({1'b0, value} + HYST_W) < {1'b0, thr};
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    if (cnt_q == CONF) alarm_d = 1'b1;
    if (sample_vld) begin
      cnt_d = over ? sat_inc(cnt_q, CONF) : '0;
      if (under) alarm_d = 1'b0;
    end
    // A fresh threshold restarts confirmation, even if a sample lands in the same cycle.
    if (clr_cnt) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;

endmodule

// File: rtl/threshold_alarm_monitor.sv
// Captures toggled threshold pairs from the setter, runs both channel comparators and
// drives alarm flags plus a mutable on/off beep pattern.
module threshold_alarm_monitor
  import threshold_alarm_monitor_pkg::*;
#(
  parameter int TEMP_RST     = TEMP_RST_DEF,
  parameter int HUM_RST      = HUM_RST_DEF,
  parameter int HYST         = 2,
  parameter int CONFIRM_N    = 3,
  parameter int BEEP_ON_CYC  = 25000000,
  parameter int BEEP_OFF_CYC = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig_newd,
  input  logic [SAMPLE_W-1:0] I_Temp,
  input  logic [SAMPLE_W-1:0] I_RH,
  input  logic [SAMPLE_W-1:0] temp,
  input  logic [SAMPLE_W-1:0] rh,
  input  logic                data_valid,
  input  logic                mute,
  output logic                thr_upd,
  output logic                alarm_temp,
  output logic                alarm_hum,
  output logic                alarm_any,
  output logic                buzzer
);

  localparam logic [BEEP_TMR_W-1:0] ON_LAST  = BEEP_TMR_W'(BEEP_ON_CYC - 1);
  localparam logic [BEEP_TMR_W-1:0] OFF_LAST = BEEP_TMR_W'(BEEP_OFF_CYC - 1);

  logic    trig_d, trig_q;
  sample_t thr_temp_d, thr_temp_q;
  sample_t thr_hum_d, thr_hum_q;
  logic    thr_upd_d, thr_upd_q;
  logic    alarm_any_d, alarm_any_q;
  logic    muted_d, muted_q;
  logic    new_thr, mute_eff;
  logic    alarm_temp_w, alarm_hum_w;

  buzz_state_t           state_q;
  logic [BEEP_TMR_W-1:0] timer_q;
  logic                  buzzer_q;

  always_comb begin
    new_thr     = trig_newd ^ trig_q;
    trig_d      = trig_newd;
    thr_temp_d  = new_thr ? I_Temp : thr_temp_q;
    thr_hum_d   = new_thr ? I_RH   : thr_hum_q;
    thr_upd_d   = new_thr;
    alarm_any_d = alarm_temp_w | alarm_hum_w;
    // Mute lasts for one alarm episode and is only accepted while that episode is active.
    muted_d = muted_q;
    if (!alarm_any_q)  muted_d = 1'b0;
    else if (mute)     muted_d = 1'b1;
    mute_eff = muted_q | (mute & alarm_any_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q      <= 1'b0;
      thr_temp_q  <= SAMPLE_W'(TEMP_RST);
      thr_hum_q   <= SAMPLE_W'(HUM_RST);
      thr_upd_q   <= 1'b0;
      alarm_any_q <= 1'b0;
      muted_q     <= 1'b0;
    end else begin
      trig_q      <= trig_d;
      thr_temp_q  <= thr_temp_d;
      thr_hum_q   <= thr_hum_d;
      thr_upd_q   <= thr_upd_d;
      alarm_any_q <= alarm_any_d;
      muted_q     <= muted_d;
    end
  end

  // Samples see the thresholds held before any same-cycle update.
  thr_channel_cmp #(.HYST(HYST), .CONFIRM_N(CONFIRM_N)) u_temp_cmp (
    .clk        (clk),
    .rst        (rst),
    .sample_vld (data_valid),
    .value      (temp),
    .thr        (thr_temp_q),
    .clr_cnt    (new_thr),
    .alarm      (alarm_temp_w)
  );

  thr_channel_cmp #(.HYST(HYST), .CONFIRM_N(CONFIRM_N)) u_hum_cmp (
    .clk        (clk),
    .rst        (rst),
    .sample_vld (data_valid),
    .value      (rh),
    .thr        (thr_hum_q),
    .clr_cnt    (new_thr),
    .alarm      (alarm_hum_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BZ_OFF;
      timer_q  <= '0;
      buzzer_q <= 1'b0;
    end else if (!alarm_any_q || mute_eff) begin
      state_q  <= BZ_OFF;
      timer_q  <= '0;
      buzzer_q <= 1'b0;
    end else begin
      case (state_q)
        BZ_OFF: begin
          state_q  <= BZ_ON;
          timer_q  <= '0;
          buzzer_q <= 1'b1;
        end
        BZ_ON: begin
          if (timer_q == ON_LAST) begin
            state_q  <= BZ_GAP;
            timer_q  <= '0;
            buzzer_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        BZ_GAP: begin
          if (timer_q == OFF_LAST) begin
            state_q  <= BZ_ON;
            timer_q  <= '0;
            buzzer_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q  <= BZ_OFF;
          timer_q  <= '0;
          buzzer_q <= 1'b0;
        end
      endcase
    end
  end

  assign thr_upd    = thr_upd_q;
  assign alarm_temp = alarm_temp_w;
  assign alarm_hum  = alarm_hum_w;
  assign alarm_any  = alarm_any_q;
  assign buzzer     = buzzer_q;

endmodule

// File: tb/tb_threshold_alarm_monitor.sv
// Directed bench: stimulus queues per-cycle expectations, a negedge monitor compares them.
module tb_threshold_alarm_monitor;

  localparam int F_U = 4;
  localparam int F_T = 3;
  localparam int F_H = 2;
  localparam int F_A = 1;
  localparam int F_B = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig_newd = 1'b0;
  logic [7:0] I_Temp = 8'd26;
  logic [7:0] I_RH = 8'd60;
  logic [7:0] temp = 8'd0;
  logic [7:0] rh = 8'd0;
  logic       data_valid = 1'b0;
  logic       mute = 1'b0;
  logic       thr_upd, alarm_temp, alarm_hum, alarm_any, buzzer;

  threshold_alarm_monitor #(.BEEP_ON_CYC(4), .BEEP_OFF_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .trig_newd  (trig_newd),
    .I_Temp     (I_Temp),
    .I_RH       (I_RH),
    .temp       (temp),
    .rh         (rh),
    .data_valid (data_valid),
    .mute       (mute),
    .thr_upd    (thr_upd),
    .alarm_temp (alarm_temp),
    .alarm_hum  (alarm_hum),
    .alarm_any  (alarm_any),
    .buzzer     (buzzer)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    fld;
    logic  val;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    int         i;
    logic [4:0] obs;
    obs = {thr_upd, alarm_temp, alarm_hum, alarm_any, buzzer};
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: check for cycle %0d never reached (now %0d)", exp_q[i].name, exp_q[i].cyc, cyc);
        exp_q.delete(i);
      end else if (exp_q[i].cyc == cyc) begin
        checks++;
        if (obs[exp_q[i].fld] !== exp_q[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %b expected %b", exp_q[i].name, cyc, obs[exp_q[i].fld], exp_q[i].val);
        end
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_at(input int d, input int fld, input logic val, input string name);
    exp_t e;
    e.cyc  = cyc + d;
    e.fld  = fld;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input logic [7:0] t, input logic [7:0] h);
    temp = t;
    rh = h;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  task automatic toggle(input logic [7:0] tt, input logic [7:0] th);
    I_Temp = tt;
    I_RH = th;
    trig_newd = ~trig_newd;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // 1: reset state and sub-threshold samples
    step(3);
    rst = 1'b0;
    expect_at(0, F_U, 1'b0, "rst_thr_upd");
    expect_at(0, F_T, 1'b0, "rst_alarm_temp");
    expect_at(0, F_H, 1'b0, "rst_alarm_hum");
    expect_at(0, F_A, 1'b0, "rst_alarm_any");
    expect_at(0, F_B, 1'b0, "rst_buzzer");
    repeat (3) sample(8'd25, 8'd0);
    expect_at(1, F_T, 1'b0, "t25_no_alarm");
    expect_at(2, F_T, 1'b0, "t25_no_alarm_late");
    expect_at(2, F_A, 1'b0, "t25_no_any");

    // 2: confirm count, hysteresis hold, clear
    repeat (3) sample(8'd27, 8'd0);
    expect_at(0, F_T, 1'b0, "t27_not_yet");
    expect_at(1, F_T, 1'b1, "t27_alarm");
    expect_at(1, F_A, 1'b0, "t27_any_lag");
    expect_at(2, F_A, 1'b1, "t27_any");
    step(4);
    sample(8'd25, 8'd0);
    expect_at(1, F_T, 1'b1, "t25_hold");
    step(2);
    sample(8'd23, 8'd0);
    expect_at(0, F_T, 1'b0, "t23_clear");
    expect_at(0, F_A, 1'b1, "t23_any_still");
    expect_at(1, F_A, 1'b0, "t23_any_clear");
    step(3);

    // 3: threshold update, old-threshold compare, counter zeroing
    toggle(8'd30, 8'd60);
    expect_at(0, F_U, 1'b1, "upd_pulse");
    expect_at(1, F_U, 1'b0, "upd_one_cycle");
    repeat (3) sample(8'd28, 8'd0);
    expect_at(1, F_T, 1'b0, "t28_thr30_none");
    expect_at(2, F_T, 1'b0, "t28_thr30_none_late");
    repeat (3) sample(8'd30, 8'd0);
    expect_at(1, F_T, 1'b1, "t30_eq_thr_alarm");
    step(2);
    expect_at(0, F_T, 1'b1, "pre_same_cycle_alarm");
    I_Temp = 8'd20;
    I_RH = 8'd60;
    trig_newd = ~trig_newd;
    temp = 8'd27;
    rh = 8'd0;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    expect_at(0, F_U, 1'b1, "same_cycle_upd");
    expect_at(0, F_T, 1'b0, "same_cycle_old_thr_clear");
    expect_at(1, F_T, 1'b0, "same_cycle_stays_clear");
    toggle(8'd26, 8'd60);
    step();
    repeat (2) sample(8'd30, 8'd0);
    toggle(8'd26, 8'd60);
    sample(8'd30, 8'd0);
    expect_at(1, F_T, 1'b0, "upd_zeroes_cnt");
    expect_at(2, F_T, 1'b0, "upd_zeroes_cnt_late");
    sample(8'd20, 8'd0);
    step(3);

    // 4: humidity alarm, beep pattern, mute, new episode
    repeat (3) sample(8'd20, 8'd70);
    expect_at(0, F_H, 1'b0, "h70_not_yet");
    expect_at(1, F_H, 1'b1, "h70_alarm");
    expect_at(2, F_A, 1'b1, "h70_any");
    expect_at(2, F_B, 1'b0, "beep_pre");
    expect_at(3, F_B, 1'b1, "beep_on_first");
    expect_at(6, F_B, 1'b1, "beep_on_last");
    expect_at(7, F_B, 1'b0, "beep_gap_first");
    expect_at(10, F_B, 1'b0, "beep_gap_last");
    expect_at(11, F_B, 1'b1, "beep_on_again");
    step(12);
    expect_at(0, F_B, 1'b1, "beep_before_mute");
    mute = 1'b1;
    step();
    mute = 1'b0;
    expect_at(0, F_B, 1'b0, "mute_silences");
    expect_at(0, F_A, 1'b1, "mute_keeps_alarm");
    expect_at(5, F_B, 1'b0, "mute_persists");
    step(6);
    sample(8'd20, 8'd50);
    expect_at(0, F_H, 1'b0, "h50_clear");
    expect_at(1, F_A, 1'b0, "h50_any_clear");
    step(3);
    mute = 1'b1;
    step();
    mute = 1'b0;
    step(2);
    repeat (3) sample(8'd20, 8'd70);
    expect_at(1, F_H, 1'b1, "h70_again");
    expect_at(3, F_B, 1'b1, "beep_new_episode");
    expect_at(4, F_B, 1'b1, "beep_new_episode2");

    // 5: back-to-back toggles, reset mid-beep
    toggle(8'd26, 8'd80);
    expect_at(0, F_U, 1'b1, "b2b_upd1");
    toggle(8'd26, 8'd90);
    expect_at(0, F_U, 1'b1, "b2b_upd2");
    expect_at(0, F_H, 1'b1, "b2b_alarm_holds");
    sample(8'd20, 8'd85);
    expect_at(0, F_U, 1'b0, "b2b_upd_end");
    expect_at(0, F_H, 1'b0, "h85_under_thr90");
    expect_at(2, F_B, 1'b0, "beep_stops_on_clear");
    step(3);
    repeat (3) sample(8'd20, 8'd95);
    expect_at(1, F_H, 1'b1, "h95_alarm");
    expect_at(3, F_B, 1'b1, "beep_before_rst");
    step(4);
    expect_at(0, F_B, 1'b1, "beep_at_rst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_at(0, F_B, 1'b0, "rst_mid_beep_buzzer");
    expect_at(0, F_H, 1'b0, "rst_mid_beep_hum");
    expect_at(0, F_A, 1'b0, "rst_mid_beep_any");
    expect_at(0, F_T, 1'b0, "rst_mid_beep_temp");
    expect_at(0, F_U, 1'b0, "rst_mid_beep_upd");
    step(2);
    repeat (3) sample(8'd20, 8'd60);
    expect_at(1, F_H, 1'b1, "h60_thr_back_to_60");
    expect_at(1, F_T, 1'b0, "t20_after_rst");
    step(4);

    if (exp_q.size() != 0) begin
      errors += exp_q.size();
      checks += exp_q.size();
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
